// File: rtl/tx_port_arbiter.sv
// tx_port_arbiter: per-requester character FIFOs feeding one framed 7-bit
// output channel. Whole messages are granted round-robin and framed as
// 0x00 (start), one character per cycle, 0x7F (end of message / idle).
module tx_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     wr_valid,
  input  logic [7*NUM_REQ-1:0]   wr_char,
  input  logic [NUM_REQ-1:0]     wr_last,
  output logic [NUM_REQ-1:0]     wr_ready,
  output logic [6:0]             tx,
  output logic                   busy,
  output logic [1:0]             grant_id
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALMOST_CNT = CW'(FIFO_DEPTH - 1);
  localparam logic [2:0]    NR         = 3'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  // The framing codes cannot appear as payload, so they are replaced by '?'.
  function automatic logic [6:0] sanitize_char(input logic [6:0] c);
    logic [6:0] r;
    if (c == 7'h00 || c == 7'h7F) r = 7'h3F;
    else                          r = c;
    return r;
  endfunction

  // (base + step) mod NUM_REQ; callers keep base < NUM_REQ and step < NUM_REQ.
  function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [2:0] step);
    logic [2:0] s;
    s = {1'b0, base} + step;
    if (s >= NR) s = s - NR;
    else         s = s;
    return s[1:0];
  endfunction

  // FIFO storage: entry = {last, char}
  logic [7:0]    mem_r     [NUM_REQ][FIFO_DEPTH];
  logic [AW-1:0] wptr_r    [NUM_REQ];
  logic [AW-1:0] rptr_r    [NUM_REQ];
  logic [CW-1:0] cnt_r     [NUM_REQ];
  logic [CW-1:0] msg_cnt_r [NUM_REQ];
  logic [7:0]    wr_entry_s[NUM_REQ];

  logic [NUM_REQ-1:0] ready_s;
  logic [NUM_REQ-1:0] push_s;
  logic [NUM_REQ-1:0] pop_s;
  logic [NUM_REQ-1:0] inc_s;
  logic [NUM_REQ-1:0] dec_s;
  logic [NUM_REQ-1:0] has_msg_s;

  // Transmit-side state
  state_t     state_r, state_nxt_s;
  logic [6:0] tx_r, tx_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic [1:0] grant_r, grant_nxt_s;
  logic [1:0] rr_ptr_r, rr_ptr_nxt_s;
  logic       last_pop_r, last_pop_nxt_s;
  logic       pop_any_s;
  logic [7:0] head_s;
  logic [1:0] pick_s;
  logic       found_s;

  // A pop happens on the START edge and on every DATA edge until the last char.
  assign pop_any_s = (state_r == ST_START) || ((state_r == ST_DATA) && !last_pop_r);

  // Write acceptance, entry formatting and per-FIFO push/pop/message events.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i]    = (cnt_r[i] != FULL_CNT) && !reset;
      push_s[i]     = wr_valid[i] && ready_s[i];
      pop_s[i]      = pop_any_s && (grant_r == 2'(i));
      // A write that fills the FIFO closes the chunk so it can always drain.
      wr_entry_s[i] = {wr_last[i] || ((cnt_r[i] == ALMOST_CNT) && !pop_s[i]),
                       sanitize_char(wr_char[7*i +: 7])};
      inc_s[i]      = push_s[i] && wr_entry_s[i][7];
      dec_s[i]      = pop_s[i] && mem_r[i][rptr_r[i]][7];
    end
  end

  // A requester is eligible once it holds at least one complete message.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      has_msg_s[i] = (msg_cnt_r[i] != {CW{1'b0}});
    end
  end

  // Head entry of the currently granted FIFO.
  always_comb begin
    head_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      head_s = (grant_r == 2'(i)) ? mem_r[i][rptr_r[i]] : head_s;
    end
  end

  // Round-robin search: first eligible requester at or after the pointer.
  always_comb begin
    pick_s  = rr_ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found_s && has_msg_s[j] && (wrap_add(rr_ptr_r, 3'(k)) == 2'(j))) begin
          found_s = 1'b1;
          pick_s  = 2'(j);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Framing FSM: next state and next registered outputs.
  always_comb begin
    state_nxt_s    = state_r;
    tx_nxt_s       = tx_r;
    busy_nxt_s     = busy_r;
    grant_nxt_s    = grant_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    last_pop_nxt_s = last_pop_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nxt_s = ST_START;
          grant_nxt_s = pick_s;
          busy_nxt_s  = 1'b1;
          tx_nxt_s    = 7'h00;
        end else begin
          tx_nxt_s    = 7'h7F;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_START: begin
        state_nxt_s    = ST_DATA;
        tx_nxt_s       = head_s[6:0];
        last_pop_nxt_s = head_s[7];
      end
      ST_DATA: begin
        if (!last_pop_r) begin
          tx_nxt_s       = head_s[6:0];
          last_pop_nxt_s = head_s[7];
        end else begin
          tx_nxt_s     = 7'h7F;
          busy_nxt_s   = 1'b0;
          rr_ptr_nxt_s = wrap_add(grant_r, 3'd1);
          state_nxt_s  = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        tx_nxt_s    = 7'h7F;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Framing FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tx_r       <= 7'h7F;
      busy_r     <= 1'b0;
      grant_r    <= 2'd0;
      rr_ptr_r   <= 2'd0;
      last_pop_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
      grant_r    <= grant_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      last_pop_r <= last_pop_nxt_s;
    end
  end

  // FIFO pointers, occupancy and complete-message counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wptr_r[i]    <= {AW{1'b0}};
        rptr_r[i]    <= {AW{1'b0}};
        cnt_r[i]     <= {CW{1'b0}};
        msg_cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push_s[i]) wptr_r[i] <= wptr_r[i] + AW'(1'b1);
        if (pop_s[i])  rptr_r[i] <= rptr_r[i] + AW'(1'b1);
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1'b1);
          2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1'b1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
        case ({inc_s[i], dec_s[i]})
          2'b10:   msg_cnt_r[i] <= msg_cnt_r[i] + CW'(1'b1);
          2'b01:   msg_cnt_r[i] <= msg_cnt_r[i] - CW'(1'b1);
          default: msg_cnt_r[i] <= msg_cnt_r[i];
        endcase
      end
    end
  end

  // FIFO storage write port; contents need no reset because pointers gate reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_s[i]) mem_r[i][wptr_r[i]] <= wr_entry_s[i];
    end
  end

  assign wr_ready = ready_s;
  assign tx       = tx_r;
  assign busy     = busy_r;
  assign grant_id = grant_r;

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Self-checking bench for tx_port_arbiter (NUM_REQ=2, FIFO_DEPTH=8).
module tb_tx_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_valid;
  logic [13:0] wr_char;
  logic [1:0]  wr_last;
  logic [1:0]  wr_ready;
  logic [6:0]  tx;
  logic        busy;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tx_port_arbiter #(.NUM_REQ(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_char(wr_char),
    .wr_last(wr_last), .wr_ready(wr_ready), .tx(tx), .busy(busy),
    .grant_id(grant_id)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [13:0] c;
    logic [1:0]  l;
    logic [6:0]  etx;
    logic        ebusy;
    logic [1:0]  egrant;
    logic [1:0]  erdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [1:0] v, input logic [13:0] c,
                     input logic [1:0] l, input logic [6:0] etx, input logic eb,
                     input logic [1:0] eg, input logic [1:0] er);
    vec_t t;
    t.rst = r; t.v = v; t.c = c; t.l = l;
    t.etx = etx; t.ebusy = eb; t.egrant = eg; t.erdy = er;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [13:0] c, input logic [1:0] l);
    reset = r; wr_valid = v; wr_char = c; wr_last = l;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      cyc();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // Collapsed tx log: runs of 0x7F are stored once.
  logic       mon_en = 1'b0;
  logic [6:0] log_q[$];
  logic [6:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (!(tx == 7'h7F && log_q.size() > 0 && log_q[$] == 7'h7F)) log_q.push_back(tx);
    end
  end

  task automatic check_stream(input string name);
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s length: got %0d expected %0d", name, log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("%s[%0d]", name, i), {25'd0, log_q[i]}, {25'd0, exp_q[i]});
      end
    end
  endtask

  task automatic start_log();
    log_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int noise;
    drive(1'b1, 2'b00, 14'h0, 2'b00);

    // "Hi" frame, then sanitised 0x00/0x7F chars, then two simultaneous messages
    add(1, 2'b00, 14'h0000, 2'b00, 7'h7F, 0, 2'd0, 2'b00);
    add(0, 2'b01, 14'h0048, 2'b00, 7'h7F, 0, 2'd0, 2'b11);
    add(0, 2'b01, 14'h0069, 2'b01, 7'h7F, 0, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h00, 1, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h48, 1, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h69, 1, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h7F, 0, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h7F, 0, 2'd0, 2'b11);
    add(0, 2'b01, 14'h0000, 2'b00, 7'h7F, 0, 2'd0, 2'b11);
    add(0, 2'b01, 14'h007F, 2'b01, 7'h7F, 0, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h00, 1, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h3F, 1, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h3F, 1, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h7F, 0, 2'd0, 2'b11);
    add(1, 2'b00, 14'h0000, 2'b00, 7'h7F, 0, 2'd0, 2'b00);
    add(0, 2'b11, {7'h42, 7'h41}, 2'b11, 7'h7F, 0, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h00, 1, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h41, 1, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h7F, 0, 2'd0, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h00, 1, 2'd1, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h42, 1, 2'd1, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h7F, 0, 2'd1, 2'b11);
    add(0, 2'b00, 14'h0000, 2'b00, 7'h7F, 0, 2'd1, 2'b11);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].v, tbl[k].c, tbl[k].l);
      cyc();
      total++;
      if (tx !== tbl[k].etx || busy !== tbl[k].ebusy ||
          grant_id !== tbl[k].egrant || wr_ready !== tbl[k].erdy) begin
        bad++;
        $display("FAIL vec%0d: got tx=%h busy=%b grant=%0d rdy=%b expected tx=%h busy=%b grant=%0d rdy=%b",
                 k, tx, busy, grant_id, wr_ready,
                 tbl[k].etx, tbl[k].ebusy, tbl[k].egrant, tbl[k].erdy);
      end
    end

    // Overlong message split at FIFO_DEPTH; wr_ready drops while full
    drive(1'b1, 2'b00, 14'h0, 2'b00);
    cyc();
    drive(1'b0, 2'b00, 14'h0, 2'b00);
    start_log();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 2'b01, {7'h00, 7'(8'h10 + k)}, 2'b00);
      cyc();
    end
    check("split_ready_full", {30'd0, wr_ready}, 32'h2);
    check("split_busy_before", {31'd0, busy}, 32'd0);
    drive(1'b0, 2'b01, {7'h00, 7'h18}, 2'b00);
    cyc();
    drive(1'b0, 2'b00, 14'h0, 2'b00);
    cyc();
    wait_idle("split_idle1", 40);
    check("split_ready_back", {30'd0, wr_ready}, 32'h3);
    drive(1'b0, 2'b01, {7'h00, 7'h18}, 2'b00);
    cyc();
    drive(1'b0, 2'b01, {7'h00, 7'h19}, 2'b01);
    cyc();
    drive(1'b0, 2'b00, 14'h0, 2'b00);
    for (int k = 0; k < 10; k++) cyc();
    wait_idle("split_idle2", 40);
    cyc();
    mon_en = 1'b0;
    exp_q.push_back(7'h7F);
    exp_q.push_back(7'h00);
    for (int k = 0; k < 8; k++) exp_q.push_back(7'(8'h10 + k));
    exp_q.push_back(7'h7F);
    exp_q.push_back(7'h00);
    exp_q.push_back(7'h18);
    exp_q.push_back(7'h19);
    exp_q.push_back(7'h7F);
    check_stream("split_stream");

    // Reset pulsed during DATA of a 5-char message
    drive(1'b1, 2'b00, 14'h0, 2'b00);
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 2'b01, {7'h00, 7'(8'h41 + k)}, (k == 4) ? 2'b01 : 2'b00);
      cyc();
    end
    drive(1'b0, 2'b00, 14'h0, 2'b00);
    n = 0;
    while (tx !== 7'h41 && n < 20) begin
      cyc();
      n++;
    end
    check("abort_reach_data", {25'd0, tx}, 32'h41);
    cyc();
    drive(1'b1, 2'b00, 14'h0, 2'b00);
    cyc();
    check("abort_tx", {25'd0, tx}, 32'h7F);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_grant", {30'd0, grant_id}, 32'd0);
    check("abort_ready_in_reset", {30'd0, wr_ready}, 32'd0);
    drive(1'b0, 2'b00, 14'h0, 2'b00);
    #1;
    check("abort_ready_after", {30'd0, wr_ready}, 32'h3);
    noise = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (tx !== 7'h7F || busy !== 1'b0) noise++;
    end
    check("abort_no_frame", noise, 32'd0);

    // Fairness: req1's pending message goes right after req0's current frame
    drive(1'b1, 2'b00, 14'h0, 2'b00);
    cyc();
    drive(1'b0, 2'b00, 14'h0, 2'b00);
    start_log();
    cyc();
    drive(1'b0, 2'b01, {7'h00, 7'h61}, 2'b00);
    cyc();
    drive(1'b0, 2'b01, {7'h00, 7'h62}, 2'b01);
    cyc();
    drive(1'b0, 2'b11, {7'h7A, 7'h63}, 2'b10);
    cyc();
    drive(1'b0, 2'b01, {7'h00, 7'h64}, 2'b01);
    cyc();
    drive(1'b0, 2'b00, 14'h0, 2'b00);
    for (int k = 0; k < 25; k++) cyc();
    mon_en = 1'b0;
    exp_q.push_back(7'h7F);
    exp_q.push_back(7'h00); exp_q.push_back(7'h61); exp_q.push_back(7'h62);
    exp_q.push_back(7'h7F);
    exp_q.push_back(7'h00); exp_q.push_back(7'h7A);
    exp_q.push_back(7'h7F);
    exp_q.push_back(7'h00); exp_q.push_back(7'h63); exp_q.push_back(7'h64);
    exp_q.push_back(7'h7F);
    check_stream("rr_stream");
    check("rr_final_grant", {30'd0, grant_id}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
